// File: rtl/posit_window_serializer.sv
// Captures one parallel layer result of NB_POSITS posits and replays it as a
// serial rts/rtr/sow/eow window, accepting the next result on the final beat.
module posit_window_serializer #(
   parameter int POSIT_WIDTH = 4,
   parameter int NB_POSITS   = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              rts_i,
   output logic                              rtr_o,
   input  logic [NB_POSITS*POSIT_WIDTH-1:0]  posits_i,
   input  logic                              rtr_i,
   output logic                              rts_o,
   output logic                              sow_o,
   output logic                              eow_o,
   output logic [POSIT_WIDTH-1:0]            posit_o
);

   localparam int IDX_W = (NB_POSITS > 1) ? $clog2(NB_POSITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITS - 1);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                   state_reg, state_next;
   logic [IDX_W-1:0]         index_reg, index_next;
   logic [POSIT_WIDTH-1:0]   bank_reg  [NB_POSITS];
   logic [POSIT_WIDTH-1:0]   posits_in [NB_POSITS];
   logic [POSIT_WIDTH-1:0]   bank_sel;
   logic                     last_beat;
   logic                     load;

   genvar gi;
   generate
      for (gi = 0; gi < NB_POSITS; gi++) begin : g_unpack
         assign posits_in[gi] = posits_i[gi*POSIT_WIDTH +: POSIT_WIDTH];
      end
      if (NB_POSITS == 1) begin : g_sel_single
         assign bank_sel = bank_reg[0];
      end else begin : g_sel_multi
         assign bank_sel = bank_reg[index_reg];
      end
   endgenerate

   assign last_beat = (index_reg == LAST_IDX);
   assign load      = rts_i & rtr_o;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         index_reg <= '0;
         for (int k = 0; k < NB_POSITS; k++) begin
            bank_reg[k] <= '0;
         end
      end else begin
         state_reg <= state_next;
         index_reg <= index_next;
         // rtr_o gates load, so the bank only changes when idle or on the last beat
         if (load) begin
            bank_reg <= posits_in;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      index_next = index_reg;
      case (state_reg)
         IDLE: begin
            if (load) begin
               state_next = STREAM;
               index_next = '0;
            end
         end
         STREAM: begin
            if (rtr_i) begin
               if (last_beat) begin
                  index_next = '0;
                  state_next = load ? STREAM : IDLE;
               end else begin
                  index_next = index_reg + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next = IDLE;
            index_next = '0;
         end
      endcase
   end

   always_comb begin
      rts_o   = (state_reg == STREAM);
      sow_o   = (state_reg == STREAM) && (index_reg == '0);
      eow_o   = (state_reg == STREAM) && last_beat;
      posit_o = (state_reg == STREAM) ? bank_sel : '0;
      // Mealy ready: the final beat frees the bank in the same cycle it drains
      rtr_o   = (state_reg == IDLE) || ((state_reg == STREAM) && last_beat && rtr_i);
   end

endmodule

// File: doc/posit_window_serializer.md
Name: posit_window_serializer

Overview:
- Transmit-side counterpart of the positron slave interface.
- Captures one parallel layer result of NB_POSITS posits, e.g. the posit_o outputs of a column of positrons gathered when their eow_o fires.
- Replays that result as a serial window on the rts/rtr/sow/eow stream protocol that feeds the next layer's positrons.
- Sits between two neural layers and provides back-to-back windows with no bubble cycles.

Parameters:
- POSIT_WIDTH, 4, width of one posit word.
- NB_POSITS, 16, posits per window (window length). Legal range is 1 or more.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rts_i  in  1  parallel result valid (slave side).
- rtr_o  out  1  block can accept a parallel result.
- posits_i  in  NB_POSITS*POSIT_WIDTH  parallel result; element k = posits_i[k*POSIT_WIDTH +: POSIT_WIDTH].
- rtr_i  in  1  downstream ready (master side).
- rts_o  out  1  serial posit valid.
- sow_o  out  1  start of window, high with element 0.
- eow_o  out  1  end of window, high with element NB_POSITS-1.
- posit_o  out  POSIT_WIDTH  current serial posit.

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, index = 0, register bank cleared to 0.
  - rts_o = 0, sow_o = 0, eow_o = 0, posit_o = 0, rtr_o = 1.
- Asserting rst mid-window aborts that window. The partially sent window is discarded and no eow_o is emitted.
- Index counter width is log2(NB_POSITS), minimum 1 bit.
- State machine, two states:
  - IDLE: rts_o = 0, rtr_o = 1. On rts_i & rtr_o, latch posits_i into the bank, set index = 0, go to STREAM.
  - STREAM: rts_o = 1. posit_o = bank[index]. sow_o = (index == 0). eow_o = (index == NB_POSITS-1).
- STREAM transfer and advance:
  - A transfer happens on rts_o & rtr_i.
  - On a transfer that is not last, index increments.
  - On the last transfer (index == NB_POSITS-1):
    - If rts_i = 1: latch the new bank, index = 0, stay in STREAM.
    - Otherwise: go to IDLE, index = 0.
- rtr_o = (state == IDLE) | (state == STREAM & index == NB_POSITS-1 & rtr_i).
  - This is a combinational path from rtr_i.
  - Upstream must not make rts_i depend on rtr_o.
- Latency: parallel capture at edge t puts element 0 on the outputs after edge t. Each window takes NB_POSITS transfer cycles under full throughput.
- Back-pressure: while rts_o & !rtr_i, all of posit_o, sow_o, eow_o and index hold stable.
- The bank is never overwritten while a window is in flight, except on the final-transfer cycle.
- NB_POSITS = 1: sow_o and eow_o are both high on the single beat. rtr_o follows rtr_i while streaming.
- rts_i asserted while in STREAM but not on the last transfer: ignored (rtr_o = 0). Upstream must hold rts_i and posits_i.
- Output data is driven only from registered state (bank, index, state). No arithmetic is performed; posits are passed through bit-exact, NaR and zero encodings included.

Test Plan:
- Reset then idle: assert rst mid-cycle. Immediately rts_o = 0, sow_o = 0, eow_o = 0, posit_o = 0, rtr_o = 1. Deassert rst with rts_i = 0: outputs unchanged for 10 cycles.
- Single window, full throughput: NB_POSITS = 4, posits_i = {4'h8, 4'h3, 4'hC, 4'h1}, rts_i for 1 cycle, rtr_i = 1. posit_o sequence is 1, C, 3, 8 on 4 consecutive cycles. sow_o only on 1, eow_o only on 8. Then rts_o = 0.
- Back-pressure: same window, rtr_i low for 3 cycles while element 2 (4'h3) is presented. posit_o = 3 and sow_o/eow_o = 0 hold all 3 cycles. The sequence resumes with no loss or duplication.
- Back-to-back windows: second window {4'h7, 4'h6, 4'h5, 4'h4} offered with rts_i held. It is accepted on the cycle 4'h8 transfers (rtr_o = 1 that cycle only). 4'h4 follows 4'h8 on the next cycle with sow_o = 1, with no bubble.
- Reset mid-window: rst pulses after 2 of 4 beats. The stream stops immediately, no eow_o is seen, rtr_o = 1. The next window starts at element 0 with sow_o.
- NB_POSITS = 1: posits_i = 4'hA, rts_i and rtr_i constantly 1. posit_o = A every cycle with sow_o = eow_o = 1, and one capture per cycle.
